// File: rtl/spice_seq_pkg.sv
// Shared types and width helpers for the phase sequencer and its step divider.
package spice_seq_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    FLIP   = 2'd2,
    ACK    = 2'd3
  } seq_state_t;

  localparam int DEF_MIN_STEPS   = 8;
  localparam int DEF_MAX_STEPS   = 64;
  localparam int DEF_QUIET_STEPS = 4;
  localparam int DEF_STEP_DIV    = 2;
  localparam int DEF_CW          = 32;

  // $clog2 that never returns 0, so a 1-value counter still gets a real bit.
  function automatic int clog2_min1(input int v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction

endpackage

// File: rtl/spice_step_divider.sv
// Integration step pacer: integ_en strobes on every STEP_DIV-th cycle while not cleared.
module spice_step_divider #(
  parameter int STEP_DIV = 2,
  parameter int DIV_W    = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic strobe
);

  localparam logic [DIV_W-1:0] LAST = DIV_W'(STEP_DIV - 1);

  logic [DIV_W-1:0] cnt;

  assign strobe = !clear && (cnt == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clear || strobe) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/spice_phase_sequencer.sv
// Paces netlist integration steps and flips the emulated chip clock once node
// activity has settled, bounded by a min/max step count per phase.
module spice_phase_sequencer
  import spice_seq_pkg::*;
#(
  parameter int MIN_STEPS   = DEF_MIN_STEPS,
  parameter int MAX_STEPS   = DEF_MAX_STEPS,
  parameter int QUIET_STEPS = DEF_QUIET_STEPS,
  parameter int STEP_DIV    = DEF_STEP_DIV,
  parameter int CW          = DEF_CW
) (
  input  logic          eclk,
  input  logic          ereset,
  input  logic          run,
  input  logic          step_req,
  output logic          step_ack,
  input  logic          activity,
  output logic          integ_en,
  output logic          phi,
  output logic          phase_start,
  output logic          busy,
  output logic          timeout,
  output logic [CW-1:0] half_cycles
);

  localparam int STEP_W = clog2_min1(MAX_STEPS + 1);
  localparam int DIV_W  = clog2_min1(STEP_DIV);
  localparam int QW     = clog2_min1(QUIET_STEPS + 1);

  // step_req handshake: a request is taken only from IDLE with run=0; step_ack
  // rises after that phase flips and stays high until step_req drops.
  seq_state_t        state, state_nx;
  logic              single_mode;
  logic [STEP_W-1:0] step_cnt, step_nx;
  logic [QW-1:0]     quiet_cnt, quiet_nx;
  logic              strobe, settled, at_max, done;

  spice_step_divider #(
    .STEP_DIV (STEP_DIV),
    .DIV_W    (DIV_W)
  ) u_div (
    .clk    (eclk),
    .rst    (ereset),
    .clear  (state != SETTLE),
    .strobe (strobe)
  );

  assign integ_en    = strobe;
  assign busy        = (state == SETTLE) || (state == FLIP);
  assign phase_start = (state == FLIP);
  assign step_ack    = (state == ACK);

  // Counts as they will be after this strobe; the exit decision uses these.
  always_comb begin
    step_nx = step_cnt + 1'b1;
    if (activity) begin
      quiet_nx = '0;
    end else if (quiet_cnt == QW'(QUIET_STEPS)) begin
      quiet_nx = quiet_cnt;
    end else begin
      quiet_nx = quiet_cnt + 1'b1;
    end
    settled = (step_nx >= STEP_W'(MIN_STEPS)) && (quiet_nx == QW'(QUIET_STEPS));
    at_max  = (step_nx == STEP_W'(MAX_STEPS));
    done    = strobe && (settled || at_max);
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (run || step_req) state_nx = SETTLE;
      SETTLE:  if (done) state_nx = FLIP;
      FLIP: begin
        if (single_mode)  state_nx = ACK;
        else if (run)     state_nx = SETTLE;
        else              state_nx = IDLE;
      end
      ACK:     if (!step_req) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge eclk or posedge ereset) begin
    if (ereset) begin
      state       <= IDLE;
      single_mode <= 1'b0;
      step_cnt    <= '0;
      quiet_cnt   <= '0;
      phi         <= 1'b0;
      half_cycles <= '0;
      timeout     <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == IDLE) single_mode <= !run;
      // Counters sit at zero outside SETTLE, so every phase entry starts clean.
      if (state != SETTLE) begin
        step_cnt  <= '0;
        quiet_cnt <= '0;
      end else if (strobe) begin
        step_cnt  <= step_nx;
        quiet_cnt <= quiet_nx;
      end
      if (done) begin
        phi         <= !phi;
        half_cycles <= half_cycles + 1'b1;
        if (at_max && !settled) timeout <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_spice_phase_sequencer.sv
// Randomized bench for spice_phase_sequencer against a per-phase step model.
module tb_spice_phase_sequencer;

  localparam int MIN_S   = 8;
  localparam int MAX_S   = 64;
  localparam int QUIET_S = 4;
  localparam int DIV     = 2;
  localparam int CW      = 32;

  logic          eclk = 1'b0;
  logic          ereset, run, step_req, activity;
  logic          step_ack, integ_en, phi, phase_start, busy, timeout;
  logic [CW-1:0] half_cycles;

  int            n_vec = 0;
  int            n_err = 0;
  bit            pat [1:MAX_S];
  bit            exp_phi;
  bit            exp_to;
  int            exp_hc;

  spice_phase_sequencer #(
    .MIN_STEPS   (MIN_S),
    .MAX_STEPS   (MAX_S),
    .QUIET_STEPS (QUIET_S),
    .STEP_DIV    (DIV),
    .CW          (CW)
  ) dut (
    .eclk        (eclk),
    .ereset      (ereset),
    .run         (run),
    .step_req    (step_req),
    .step_ack    (step_ack),
    .activity    (activity),
    .integ_en    (integ_en),
    .phi         (phi),
    .phase_start (phase_start),
    .busy        (busy),
    .timeout     (timeout),
    .half_cycles (half_cycles)
  );

  // clock / reset
  always #5 eclk = ~eclk;

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Step count of a phase: first step at/after MIN_S whose last QUIET_S steps
  // were all activity-free, else the MAX_S budget (a timeout if not quiet there).
  function automatic int model_steps(output bit to_hit);
    bit quiet;
    for (int k = 1; k <= MAX_S; k++) begin
      quiet = (k >= QUIET_S);
      if (quiet) begin
        for (int j = 0; j < QUIET_S; j++) if (pat[k - j]) quiet = 1'b0;
      end
      if ((k >= MIN_S && quiet) || k == MAX_S) begin
        to_hit = !quiet;
        return k;
      end
    end
    to_hit = 1'b1;
    return MAX_S;
  endfunction

  task automatic fill_pat(input int kind);
    int dens;
    dens = $urandom_range(0, 6);
    for (int k = 1; k <= MAX_S; k++) begin
      case (kind)
        0:       pat[k] = 1'b0;
        1:       pat[k] = (k <= 10);
        2:       pat[k] = 1'b1;
        default: pat[k] = ($urandom_range(0, 9) < dens);
      endcase
    end
  endtask

  task automatic idle_check(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(negedge eclk);
      check("idle_busy", busy, 1'b0);
      check("idle_integ_en", integ_en, 1'b0);
      check("idle_phase_start", phase_start, 1'b0);
      check("idle_step_ack", step_ack, 1'b0);
      check("idle_phi", phi, exp_phi);
      check("idle_half_cycles", half_cycles, exp_hc);
    end
  endtask

  // One phase from its first SETTLE cycle through FLIP (and ACK when single).
  task automatic do_phase(input bit single, input bit next_run);
    int n, h;
    bit to_hit;
    n = model_steps(to_hit);
    for (int c = 0; c < n * DIV; c++) begin
      @(negedge eclk);
      check("settle_integ_en", integ_en, ((c + 1) % DIV) == 0);
      check("settle_busy", busy, 1'b1);
      check("settle_phi", phi, exp_phi);
      check("settle_phase_start", phase_start, 1'b0);
      check("settle_step_ack", step_ack, 1'b0);
      check("settle_timeout", timeout, exp_to);
      if (((c + 1) % DIV) == 0) activity = pat[(c + 1) / DIV];
      else activity = 1'($urandom_range(0, 1));
      run = 1'($urandom_range(0, 1));
      if (!single) step_req = 1'($urandom_range(0, 1));
    end
    exp_phi = !exp_phi;
    exp_hc  = exp_hc + 1;
    exp_to  = exp_to | to_hit;
    @(negedge eclk);
    check("flip_phase_start", phase_start, 1'b1);
    check("flip_phi", phi, exp_phi);
    check("flip_half_cycles", half_cycles, exp_hc);
    check("flip_timeout", timeout, exp_to);
    check("flip_integ_en", integ_en, 1'b0);
    check("flip_busy", busy, 1'b1);
    if (single) begin
      run = 1'($urandom_range(0, 1));
      h = $urandom_range(1, 4);
      for (int i = 0; i < h; i++) begin
        @(negedge eclk);
        check("ack_step_ack", step_ack, 1'b1);
        check("ack_busy", busy, 1'b0);
        check("ack_integ_en", integ_en, 1'b0);
        if (i == h - 1) begin
          step_req = 1'b0;
          run = 1'b0;
        end else begin
          run = 1'($urandom_range(0, 1));
        end
      end
      @(negedge eclk);
      check("ack_release", step_ack, 1'b0);
      check("ack_release_busy", busy, 1'b0);
      check("ack_release_integ_en", integ_en, 1'b0);
    end else begin
      run = next_run;
      step_req = 1'b0;
    end
  endtask

  initial begin
    ereset = 1'b1;
    run = 1'b0;
    step_req = 1'b0;
    activity = 1'b0;
    exp_phi = 1'b0;
    exp_hc = 0;
    exp_to = 1'b0;
    repeat (2) @(negedge eclk);
    check("rst_phi", phi, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_integ_en", integ_en, 1'b0);
    check("rst_timeout", timeout, 1'b0);
    check("rst_half_cycles", half_cycles, 0);
    ereset = 1'b0;
    idle_check(2);

    // free run: quiet phases, then activity on steps 1-10, then stuck activity
    run = 1'b1;
    for (int p = 0; p < 3; p++) begin
      fill_pat(0);
      do_phase(1'b0, 1'b1);
    end
    fill_pat(1);
    do_phase(1'b0, 1'b1);
    fill_pat(2);
    do_phase(1'b0, 1'b1);
    fill_pat(0);
    do_phase(1'b0, 1'b1);
    for (int r = 0; r < 6; r++) begin
      fill_pat(3);
      do_phase(1'b0, r != 5);
    end
    idle_check(3);

    // single half-cycle handshake
    step_req = 1'b1;
    run = 1'b0;
    fill_pat(0);
    do_phase(1'b1, 1'b0);
    idle_check(3);

    // free phase with run toggling mid-phase, ending in IDLE
    run = 1'b1;
    fill_pat(0);
    do_phase(1'b0, 1'b0);
    idle_check(4);

    // asynchronous reset in the middle of a phi=1 phase
    run = 1'b1;
    fill_pat(0);
    if (!exp_phi) do_phase(1'b0, 1'b1);
    activity = 1'b0;
    repeat (5) @(negedge eclk);
    check("pre_rst_phi", phi, 1'b1);
    #2 ereset = 1'b1;
    #1;
    check("async_rst_phi", phi, 1'b0);
    check("async_rst_half_cycles", half_cycles, 0);
    check("async_rst_busy", busy, 1'b0);
    check("async_rst_integ_en", integ_en, 1'b0);
    check("async_rst_timeout", timeout, 1'b0);
    run = 1'b0;
    repeat (2) @(negedge eclk);
    ereset = 1'b0;
    exp_phi = 1'b0;
    exp_hc = 0;
    exp_to = 1'b0;
    idle_check(2);
    step_req = 1'b1;
    fill_pat(3);
    do_phase(1'b1, 1'b0);
    idle_check(3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/spice_phase_sequencer.md
Name: spice_phase_sequencer

Overview:
- Sequences the switch-level/analog netlist datapath: paces node integration steps and generates the emulated chip clock (e.g. 6502 phi0) driven into a spice_pin_input.
- Holds each emulated clock phase until node activity settles, bounded by a minimum and maximum number of integration steps.
- Host controls it through free-run and single-half-cycle handshakes.
- Sits between host control logic and the top-level netlist instance.

Parameters:
- MIN_STEPS, 8: minimum integration steps per phase (>=1).
- MAX_STEPS, 64: step budget per phase; reaching it forces a phase flip and sets timeout (>= MIN_STEPS).
- QUIET_STEPS, 4: consecutive activity-free steps required to declare settled (>=1).
- STEP_DIV, 2: eclk cycles per integration step (>=1); integ_en strobes once per STEP_DIV cycles.
- CW, 32: half-cycle counter width.

Ports:
- eclk  input  1  system clock.
- ereset  input  1  reset, asynchronous, active-high.
- run  input  1  level; 1 = free-run half-cycles continuously.
- step_req  input  1  single half-cycle request (4-phase handshake).
- step_ack  output  1  single half-cycle done; held until step_req drops.
- activity  input  1  netlist reports a node sign-bit change during the last step.
- integ_en  output  1  one-eclk strobe that commits one integration step in the netlist.
- phi  output  1  emulated chip clock level.
- phase_start  output  1  one-eclk pulse on the cycle phi toggles.
- busy  output  1  a phase is in progress.
- timeout  output  1  sticky; some phase hit MAX_STEPS.
- half_cycles  output  CW  completed phases; wraps modulo 2^CW.

Behaviour:
- Reset values (asynchronous): state IDLE; phi, integ_en, phase_start, step_ack, busy, timeout = 0; all counters 0.
- States: IDLE, SETTLE, FLIP, ACK.
- IDLE -> SETTLE when run=1, or when step_req=1 with run=0. On entry, clear step_cnt, quiet_cnt and the divider. Record mode: free or single.
- SETTLE:
  - busy=1.
  - Divider counts 0..STEP_DIV-1; integ_en=1 on the cycle the divider equals STEP_DIV-1. The first strobe therefore occurs STEP_DIV cycles after entry.
  - On each strobe cycle: step_cnt+1. quiet_cnt becomes 0 if activity=1, otherwise quiet_cnt+1, saturating at QUIET_STEPS. activity is ignored on non-strobe cycles.
  - Exit to FLIP on the strobe cycle where the updated counts satisfy (step_cnt>=MIN_STEPS and quiet_cnt>=QUIET_STEPS), or step_cnt==MAX_STEPS.
  - If the exit is due to MAX_STEPS and the quiet condition is not met, set timeout. Both conditions true on the same strobe is not a timeout.
- FLIP (one cycle):
  - Toggle phi, pulse phase_start, half_cycles+1, integ_en=0, busy=1.
  - Next state: free mode with run=1 -> SETTLE (counters cleared). Free mode with run=0 -> IDLE. Single mode -> ACK.
- ACK:
  - step_ack=1, busy=0. Return to IDLE when step_req=0; step_ack falls on that transition.
  - run rising during ACK is ignored until IDLE.
- run deassertion mid-phase: the current phase completes normally; phases are never truncated.
- step_req while run=1: ignored; no ack is generated.
- run rising during a single-mode phase: the phase completes as single mode (ACK first).
- timeout clears only on ereset.
- Reset mid-phase: immediate return to reset values. phi returns to 0.
- Minimum half-cycle length is MIN_STEPS*STEP_DIV+1 eclk; maximum is MAX_STEPS*STEP_DIV+1.

Decomposition:
- Package spice_seq_pkg: state enum; STEP_W = $clog2(MAX_STEPS+1); DIV_W = $clog2(STEP_DIV) (min 1).
- One sub-module, spice_step_divider: divider plus integ_en strobe, with clear input.
- Settle/quiet counters and FSM live in the top module.

Test Plan:
- Reset then run=1 with activity=0 (defaults): phi toggles every 8*2+1=17 eclk. phase_start pulses, half_cycles=1,2,3. integ_en shows 8 strobes per phase. timeout=0.
- run=1, activity=1 on strobes 1-10 then 0: flip on strobe 14 (10 active steps + 4 quiet), phase length 29 eclk. timeout=0.
- activity stuck at 1: flip after strobe 64 (129 eclk). timeout=1 and stays 1 through later quiet phases until ereset.
- run=0, step_req raised: exactly one phase (17 eclk), phi 0->1. step_ack held while step_req=1, drops the cycle after step_req=0. half_cycles=1, no further integ_en strobes.
- run dropped at strobe 3 of a phase: phase completes at strobe 8, then IDLE. integ_en stays 0 afterwards. busy falls the cycle after FLIP.
- ereset asserted mid-SETTLE (phi=1, half_cycles=5): outputs zero asynchronously, before the next eclk edge. Next run restarts from phi=0, half_cycles=0.
